mult_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one external multiplier among the neurons of a layer. Each neuron requests the multiplier, receives a one-hot grant, and presents operands with a start strobe. The arbiter issues exactly one multiply per grant, returns the product with a held done flag, and rotates priority when the owner releases its request. It sits between a layer's neuron instances and the layer's multiplier.

---
 rtl/mult_arbiter.sv | 159 +++++++++++++++
 tb/tb_mult_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_arbiter.sv
// Round-robin arbiter/sequencer sharing one external multiplier among a layer's neurons.
// One multiply is issued per grant. Priority rotates when the owner releases its request.
module mult_arbiter #(
  parameter int unsigned NumRequesters = 5,
  parameter int unsigned DataWidth     = 8,
  parameter int unsigned CountWidth    = 16
) (
  input  logic                               clk_i,
  input  logic                               reset_ni,
  input  logic [NumRequesters-1:0]           req_i,
  output logic [NumRequesters-1:0]           grant_o,
  input  logic [NumRequesters-1:0]           start_i,
  input  logic [NumRequesters*DataWidth-1:0] a_i,
  input  logic [NumRequesters*DataWidth-1:0] b_i,
  output logic [NumRequesters-1:0]           done_o,
  output logic                               busy_o,
  output logic [2*DataWidth-1:0]             result_o,
  output logic                               mult_start_o,
  output logic [DataWidth-1:0]               mult_a_o,
  output logic [DataWidth-1:0]               mult_b_o,
  input  logic                               mult_busy_i,
  input  logic                               mult_done_i,
  input  logic [2*DataWidth-1:0]             mult_result_i,
  output logic [CountWidth-1:0]              ops_count_o,
  output logic                               protocol_err_o
);

  localparam int unsigned IdxWidth  = (NumRequesters > 1) ? $clog2(NumRequesters) : 1;
  localparam int unsigned ProdWidth = 2 * DataWidth;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_GRANT = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e                   state_q;
  logic [IdxWidth-1:0]      owner_q;
  logic [IdxWidth-1:0]      ptr_q;
  logic [NumRequesters-1:0] grant_q;
  logic [NumRequesters-1:0] done_q;
  logic                     busy_q;
  logic [ProdWidth-1:0]     result_q;
  logic                     start_q;
  logic [DataWidth-1:0]     a_q;
  logic [DataWidth-1:0]     b_q;
  logic [CountWidth-1:0]    ops_q;
  logic                     err_q;

  logic                     pick_valid_c;
  logic [IdxWidth-1:0]      pick_idx_c;
  logic [IdxWidth-1:0]      cand_c;
  logic [DataWidth-1:0]     own_a_c;
  logic [DataWidth-1:0]     own_b_c;

  // First requester at or after ptr+1, wrapping; the pointer alone breaks ties.
  always_comb begin
    pick_valid_c = 1'b0;
    pick_idx_c   = '0;
    cand_c       = '0;
    for (int unsigned i = 1; i <= NumRequesters; i++) begin
      cand_c = IdxWidth'((32'(ptr_q) + i) % NumRequesters);
      if (!pick_valid_c && req_i[cand_c]) begin
        pick_valid_c = 1'b1;
        pick_idx_c   = cand_c;
      end
    end
  end

  assign own_a_c = a_i[owner_q*DataWidth +: DataWidth];
  assign own_b_c = b_i[owner_q*DataWidth +: DataWidth];

  // Sequencer: grant, issue one multiply, wait for the product, hold done until release.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q  <= S_IDLE;
      owner_q  <= '0;
      ptr_q    <= IdxWidth'(NumRequesters - 1);
      grant_q  <= '0;
      done_q   <= '0;
      busy_q   <= 1'b0;
      result_q <= '0;
      start_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      ops_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      // A done pulse outside WAIT has no operation to complete; flag it sticky.
      if (mult_done_i && (state_q != S_WAIT)) begin
        err_q <= 1'b1;
      end
      case (state_q)
        S_IDLE: begin
          if (pick_valid_c) begin
            owner_q <= pick_idx_c;
            grant_q <= NumRequesters'(1) << pick_idx_c;
            busy_q  <= 1'b1;
            state_q <= S_GRANT;
          end
        end
        S_GRANT: begin
          if (start_i[owner_q] && !mult_busy_i) begin
            a_q     <= own_a_c;
            b_q     <= own_b_c;
            start_q <= 1'b1;
            state_q <= S_ISSUE;
          end else if (!req_i[owner_q]) begin
            grant_q <= '0;
            ptr_q   <= owner_q;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        S_ISSUE: begin
          start_q <= 1'b0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (mult_done_i) begin
            result_q <= mult_result_i;
            done_q   <= NumRequesters'(1) << owner_q;
            state_q  <= S_DONE;
          end
        end
        S_DONE: begin
          if (!req_i[owner_q]) begin
            grant_q <= '0;
            done_q  <= '0;
            ptr_q   <= owner_q;
            ops_q   <= ops_q + CountWidth'(1);
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: begin
          grant_q <= '0;
          done_q  <= '0;
          start_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign grant_o        = grant_q;
  assign done_o         = done_q;
  assign busy_o         = busy_q;
  assign result_o       = result_q;
  assign mult_start_o   = start_q;
  assign mult_a_o       = a_q;
  assign mult_b_o       = b_q;
  assign ops_count_o    = ops_q;
  assign protocol_err_o = err_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed bench for mult_arbiter with a scoreboard of expected products.
module tb_mult_arbiter;

  localparam int unsigned N  = 5;
  localparam int unsigned DW = 8;
  localparam int unsigned CW = 16;

  logic            clk_i = 1'b0;
  logic            reset_ni;
  logic [N-1:0]    req_i;
  logic [N-1:0]    grant_o;
  logic [N-1:0]    start_i;
  logic [N*DW-1:0] a_i;
  logic [N*DW-1:0] b_i;
  logic [N-1:0]    done_o;
  logic            busy_o;
  logic [2*DW-1:0] result_o;
  logic            mult_start_o;
  logic [DW-1:0]   mult_a_o;
  logic [DW-1:0]   mult_b_o;
  logic            mult_busy_i;
  logic            mult_done_i;
  logic [2*DW-1:0] mult_result_i;
  logic [CW-1:0]   ops_count_o;
  logic            protocol_err_o;

  int vectors = 0;
  int errors  = 0;
  int exp_ops = 0;
  logic [15:0] exp_q[$];

  mult_arbiter #(.NumRequesters(N), .DataWidth(DW), .CountWidth(CW)) dut (
    .clk_i(clk_i), .reset_ni(reset_ni), .req_i(req_i), .grant_o(grant_o),
    .start_i(start_i), .a_i(a_i), .b_i(b_i), .done_o(done_o), .busy_o(busy_o),
    .result_o(result_o), .mult_start_o(mult_start_o), .mult_a_o(mult_a_o),
    .mult_b_o(mult_b_o), .mult_busy_i(mult_busy_i), .mult_done_i(mult_done_i),
    .mult_result_i(mult_result_i), .ops_count_o(ops_count_o),
    .protocol_err_o(protocol_err_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [31:0] oh(input int k);
    return 32'(1) << k;
  endfunction

  // Owner slice gets the real operands, every other slice gets noise.
  task automatic set_ops(input int k, input logic [7:0] a, input logic [7:0] b);
    for (int j = 0; j < int'(N); j++) begin
      a_i[j*DW +: DW] = 8'($urandom);
      b_i[j*DW +: DW] = 8'($urandom);
    end
    a_i[k*DW +: DW] = a;
    b_i[k*DW +: DW] = b;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_grant"}, 32'(grant_o), 32'(0));
    chk({tag, "_done"}, 32'(done_o), 32'(0));
    chk({tag, "_busy"}, 32'(busy_o), 32'(0));
    chk({tag, "_mstart"}, 32'(mult_start_o), 32'(0));
    chk({tag, "_ma"}, 32'(mult_a_o), 32'(0));
    chk({tag, "_mb"}, 32'(mult_b_o), 32'(0));
    chk({tag, "_result"}, 32'(result_o), 32'(0));
    chk({tag, "_ops"}, 32'(ops_count_o), 32'(0));
    chk({tag, "_perr"}, 32'(protocol_err_o), 32'(0));
  endtask

  // Owner k already holds the grant (state GRANT); run one full transaction and release.
  task automatic run_txn(input int k, input logic [7:0] a, input logic [7:0] b,
                         input int busy_cyc, input int start_hold, input int done_delay,
                         input bit drop_in_wait, input bit rerequest);
    int pulses;
    logic [31:0] want;
    pulses = 0;
    set_ops(k, a, b);
    start_i[k]  = 1'b1;
    mult_busy_i = (busy_cyc > 0);
    for (int i = 0; i < busy_cyc; i++) begin
      tick();
      chk("stall_no_start", 32'(mult_start_o), 32'(0));
      chk("stall_grant_held", 32'(grant_o), oh(k));
    end
    mult_busy_i = 1'b0;
    exp_q.push_back(16'(a) * 16'(b));
    tick();
    chk("start_pulse", 32'(mult_start_o), 32'(1));
    chk("mult_a", 32'(mult_a_o), 32'(a));
    chk("mult_b", 32'(mult_b_o), 32'(b));
    tick();
    chk("start_low", 32'(mult_start_o), 32'(0));
    for (int i = 0; i < start_hold; i++) begin
      tick();
      pulses += int'(mult_start_o);
    end
    if (start_hold > 0) chk("single_start_pulse", 32'(pulses), 32'(0));
    start_i[k] = 1'b0;
    if (drop_in_wait) req_i[k] = 1'b0;
    for (int i = 0; i < done_delay; i++) begin
      tick();
      chk("done_wait_low", 32'(done_o), 32'(0));
    end
    mult_done_i   = 1'b1;
    mult_result_i = 16'(mult_a_o) * 16'(mult_b_o);
    tick();
    mult_done_i   = 1'b0;
    mult_result_i = '0;
    want = (exp_q.size() > 0) ? {16'h0, exp_q.pop_front()} : 32'hDEAD_BEEF;
    chk("done_flag", 32'(done_o), oh(k));
    chk("result", 32'(result_o), want);
    chk("grant_in_done", 32'(grant_o), oh(k));
    if (!drop_in_wait) begin
      for (int i = 0; i < 2; i++) begin
        tick();
        chk("done_held", 32'(done_o), oh(k));
        chk("result_held", 32'(result_o), want);
      end
      req_i[k] = 1'b0;
    end
    tick();
    exp_ops++;
    chk("release_grant", 32'(grant_o), 32'(0));
    chk("release_done", 32'(done_o), 32'(0));
    chk("ops_count", 32'(ops_count_o), 32'(exp_ops));
    chk("release_busy", 32'(busy_o), 32'(0));
    if (rerequest) req_i[k] = 1'b1;
  endtask

  initial begin
    int order[6];
    order = '{0, 1, 2, 3, 4, 0};
    reset_ni = 1'b1; req_i = '0; start_i = '0; a_i = '0; b_i = '0;
    mult_busy_i = 1'b0; mult_done_i = 1'b0; mult_result_i = '0;
    #2 reset_ni = 1'b0;
    tick();
    chk_reset_outputs("reset");
    tick();
    reset_ni = 1'b1;

    // Single request: 3*5 with done 4 cycles after start.
    req_i[0] = 1'b1;
    tick();
    chk("single_grant", 32'(grant_o), oh(0));
    chk("single_busy", 32'(busy_o), 32'(1));
    run_txn(0, 8'd3, 8'd5, 0, 0, 3, 1'b0, 1'b0);

    // Fresh reset so the pointer favours requester 0 again.
    reset_ni = 1'b0;
    tick();
    reset_ni = 1'b1;
    exp_ops = 0;

    // All five requesting: rotation 0,1,2,3,4,0.
    req_i = 5'b11111;
    for (int s = 0; s < 6; s++) begin
      tick();
      chk("rr_grant", 32'(grant_o), oh(order[s]));
      run_txn(order[s], 8'(s * 7 + 2), 8'(s * 13 + 9), 0, 0, 1, 1'b0, s < 5);
    end
    req_i = '0;

    // Start held 10 cycles, done delayed 8: exactly one pulse.
    req_i[2] = 1'b1;
    tick();
    chk("hold_grant", 32'(grant_o), oh(2));
    run_txn(2, 8'd17, 8'd11, 0, 10, 8, 1'b0, 1'b0);

    // Abandoned grant: released with no count, pointer moves to 3.
    req_i[3] = 1'b1;
    tick();
    chk("abandon_grant", 32'(grant_o), oh(3));
    req_i[3] = 1'b0;
    tick();
    chk("abandon_release", 32'(grant_o), 32'(0));
    chk("abandon_ops", 32'(ops_count_o), 32'(exp_ops));
    chk("abandon_busy", 32'(busy_o), 32'(0));
    req_i = 5'b10010;
    tick();
    chk("ptr_advance_grant", 32'(grant_o), oh(4));
    run_txn(4, 8'd200, 8'd3, 0, 0, 2, 1'b1, 1'b0);
    tick();
    chk("next_grant", 32'(grant_o), oh(1));
    run_txn(1, 8'd12, 8'd12, 3, 0, 2, 1'b0, 1'b0);

    // Spurious done while idle.
    mult_done_i = 1'b1;
    tick();
    mult_done_i = 1'b0;
    chk("spurious_err", 32'(protocol_err_o), 32'(1));
    tick();
    chk("spurious_err_sticky", 32'(protocol_err_o), 32'(1));
    chk("spurious_idle", 32'(busy_o), 32'(0));

    // Reset while a multiply is in flight, then a late done.
    req_i[0] = 1'b1;
    tick();
    chk("inflight_grant", 32'(grant_o), oh(0));
    set_ops(0, 8'd9, 8'd7);
    start_i[0] = 1'b1;
    exp_q.push_back(16'd63);
    tick();
    start_i[0] = 1'b0;
    tick();
    tick();
    chk("inflight_busy", 32'(busy_o), 32'(1));
    #2 reset_ni = 1'b0;
    req_i = '0;
    #1;
    chk_reset_outputs("async_reset");
    exp_q.delete();
    exp_ops = 0;
    tick();
    reset_ni = 1'b1;
    mult_done_i   = 1'b1;
    mult_result_i = 16'h0123;
    tick();
    mult_done_i   = 1'b0;
    mult_result_i = '0;
    chk("late_done_err", 32'(protocol_err_o), 32'(1));
    chk("late_done_ignored", 32'(result_o), 32'(0));
    req_i[0] = 1'b1;
    tick();
    chk("max_grant", 32'(grant_o), oh(0));
    run_txn(0, 8'd255, 8'd255, 0, 0, 2, 1'b0, 1'b0);
    chk("max_err_sticky", 32'(protocol_err_o), 32'(1));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
